// File: rtl/apb_slave_regfile_if.sv
// APB bus bundle between the SoC APB master and the register-file completer.
// PSEL/PENABLE/PREADY handshake: a transfer completes in the cycle where
// PSEL && PENABLE && PREADY are all high. Address, direction, write data and
// strobes must be held stable by the master until that cycle.
interface apb_slave_regfile_if;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic        PREADY;
  logic [31:0] PRDATA;
  logic        PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    input  PREADY, PRDATA, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    output PREADY, PRDATA, PSLVERR
  );
endinterface

// File: rtl/apb_slave_regfile.sv
// APB completer exposing NUM_REGS 32-bit registers. Register 0 is a constant
// ID word; the others are byte-lane writable. A fixed number of wait states
// precedes PREADY, bad accesses answer with PSLVERR, and every committed write
// raises a one-cycle pulse for the affected register towards the peripheral.
module apb_slave_regfile #(
  parameter int          NUM_REGS    = 8,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] ID_VALUE    = 32'hA9B0_0001
) (
  input  logic                   PCLK,
  input  logic                   PRESETn,
  apb_slave_regfile_if.slave     apb,
  output logic [NUM_REGS*32-1:0] regs_o,
  output logic [NUM_REGS-1:0]    wr_pulse_o,
  output logic [1:0]             fsm_state_o
);

  localparam int          IDX_W     = $clog2(NUM_REGS);
  localparam logic [31:0] SPAN      = 32'(NUM_REGS * 4);
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] regs_q [1:NUM_REGS-1];

  logic             setup_phase;
  logic             complete;
  logic [31:0]      offset;
  logic             addr_ok;
  logic [IDX_W-1:0] idx;
  logic             err;
  logic             commit;
  logic [31:0]      rd_word;

  // Address decode, error classification and completion qualifiers.
  always_comb begin
    setup_phase = apb.PSEL && !apb.PENABLE;
    complete    = (state_q == S_DONE) && apb.PSEL && apb.PENABLE;
    offset      = apb.PADDR - BASE_ADDR;
    addr_ok     = (apb.PADDR >= BASE_ADDR) && (offset < SPAN) &&
                  (apb.PADDR[1:0] == 2'b00);
    idx         = offset[IDX_W+1:2];
    // Writing the ID register with any lane enabled is refused; an empty
    // strobe there is a harmless no-op.
    err         = !addr_ok ||
                  (apb.PWRITE && (idx == '0) && (apb.PSTRB != 4'b0000));
    commit      = complete && apb.PWRITE && !err && (apb.PSTRB != 4'b0000);
    // regs_o already carries the ID word in slot 0, so it doubles as read mux.
    rd_word     = regs_o[{idx, 5'b00000} +: 32];
  end

  // Bus response: only meaningful in the completing cycle, zero elsewhere.
  always_comb begin
    apb.PREADY  = complete;
    apb.PSLVERR = complete && err;
    apb.PRDATA  = (complete && !apb.PWRITE && !err) ? rd_word : 32'h0;
  end

  // Transfer FSM: counts wait states, then holds DONE until the access ends.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (setup_phase) begin
            cnt_q   <= WAIT_INIT;
            state_q <= (WAIT_INIT != 4'd0) ? S_WAIT : S_DONE;
          end
        end
        S_WAIT: begin
          if (!apb.PSEL) begin
            state_q <= S_IDLE;
          end else if (apb.PENABLE) begin
            cnt_q <= cnt_q - 4'd1;
            if (cnt_q <= 4'd1) state_q <= S_DONE;
          end
        end
        S_DONE: begin
          if (!apb.PSEL) begin
            state_q <= S_IDLE;
          end else if (!apb.PENABLE) begin
            // Master went straight to a new setup phase: restart the count.
            cnt_q   <= WAIT_INIT;
            state_q <= (WAIT_INIT != 4'd0) ? S_WAIT : S_DONE;
          end else begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Register bank update with byte-lane strobes and the per-register pulse.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int k = 1; k < NUM_REGS; k++) regs_q[k] <= 32'h0;
      wr_pulse_o <= '0;
    end else begin
      wr_pulse_o <= '0;
      for (int k = 1; k < NUM_REGS; k++) begin
        if (commit && (idx == IDX_W'(k))) begin
          wr_pulse_o[k] <= 1'b1;
          for (int b = 0; b < 4; b++) begin
            if (apb.PSTRB[b]) regs_q[k][8*b +: 8] <= apb.PWDATA[8*b +: 8];
          end
        end
      end
    end
  end

  assign regs_o[31:0] = ID_VALUE;
  for (genvar k = 1; k < NUM_REGS; k++) begin : g_regs_out
    assign regs_o[32*k +: 32] = regs_q[k];
  end

  assign fsm_state_o = state_q;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Bench for apb_slave_regfile: two instances share one set of bus wires and
// are told apart by their PSEL. Instance A: 8 regs, base 0, 1 wait state.
// Instance B: 4 regs, base 0x1000, no wait states. A register-array model
// computes every expected response from the address map rules.
module tb_apb_slave_regfile;

  localparam logic [31:0] ID = 32'hA9B0_0001;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic [1:0]  psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;

  logic [255:0] regs_a;
  logic [127:0] regs_b;
  logic [7:0]   pulse_a;
  logic [3:0]   pulse_b;
  logic [1:0]   st_a;
  logic [1:0]   st_b;

  apb_slave_regfile_if bus_a ();
  apb_slave_regfile_if bus_b ();

  assign bus_a.PSEL    = psel[0];
  assign bus_a.PENABLE = penable;
  assign bus_a.PWRITE  = pwrite;
  assign bus_a.PADDR   = paddr;
  assign bus_a.PWDATA  = pwdata;
  assign bus_a.PSTRB   = pstrb;
  assign bus_b.PSEL    = psel[1];
  assign bus_b.PENABLE = penable;
  assign bus_b.PWRITE  = pwrite;
  assign bus_b.PADDR   = paddr;
  assign bus_b.PWDATA  = pwdata;
  assign bus_b.PSTRB   = pstrb;

  apb_slave_regfile #(
    .NUM_REGS(8), .BASE_ADDR(32'h0000_0000), .WAIT_CYCLES(1), .ID_VALUE(ID)
  ) dut_a (
    .PCLK(PCLK), .PRESETn(PRESETn), .apb(bus_a.slave),
    .regs_o(regs_a), .wr_pulse_o(pulse_a), .fsm_state_o(st_a)
  );

  apb_slave_regfile #(
    .NUM_REGS(4), .BASE_ADDR(32'h0000_1000), .WAIT_CYCLES(0), .ID_VALUE(ID)
  ) dut_b (
    .PCLK(PCLK), .PRESETn(PRESETn), .apb(bus_b.slave),
    .regs_o(regs_b), .wr_pulse_o(pulse_b), .fsm_state_o(st_b)
  );

  // clock / reset
  always #5 PCLK = ~PCLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // reference model
  int          errors = 0;
  int          checks = 0;
  logic [31:0] mdl [2][8];
  int          nregs [2] = '{8, 4};
  logic [31:0] base  [2] = '{32'h0000_0000, 32'h0000_1000};
  int          waitc [2] = '{1, 0};
  logic [31:0] last_rd;
  logic        last_err;

  function automatic void m_reset();
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < 8; k++) mdl[d][k] = 32'h0;
  endfunction

  function automatic logic [255:0] m_regs(input int d);
    logic [255:0] v = '0;
    for (int k = 0; k < nregs[d]; k++) v[k*32 +: 32] = (k == 0) ? ID : mdl[d][k];
    return v;
  endfunction

  function automatic logic rdy(input int d);
    return d ? bus_b.PREADY : bus_a.PREADY;
  endfunction

  function automatic logic [31:0] rdata(input int d);
    return d ? bus_b.PRDATA : bus_a.PRDATA;
  endfunction

  function automatic logic slverr(input int d);
    return d ? bus_b.PSLVERR : bus_a.PSLVERR;
  endfunction

  // scoreboard check
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic chk_regs();
    chk("regs_a", regs_a, m_regs(0));
    chk("regs_b", {128'h0, regs_b}, m_regs(1));
  endtask

  // driver: one full transfer, leaves PSEL high after the completing edge
  task automatic xfer(input int d, input bit wr, input logic [31:0] addr,
                      input logic [31:0] data, input logic [3:0] strb);
    int          lat = 0;
    bit          done = 0;
    logic [31:0] rd = 32'h0;
    logic        er = 1'b0;
    longint      off;
    bit          valid;
    int          idx;
    bit          exp_err;
    bit          commit;
    logic [31:0] exp_rd;
    logic [11:0] exp_pulse;

    psel = 2'b00; psel[d] = 1'b1;
    penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
    @(posedge PCLK); #1;
    chk("pulse_one_cycle", {pulse_b, pulse_a}, 12'h0);
    penable = 1'b1;
    while (!done && lat < 40) begin
      @(negedge PCLK);
      lat++;
      if (rdy(d)) begin
        rd = rdata(d); er = slverr(d); done = 1;
      end else begin
        chk("prdata_not_done", rdata(d), 32'h0);
        chk("pslverr_not_done", slverr(d), 1'b0);
        @(posedge PCLK); #1;
      end
    end
    chk("pready_timeout", done, 1'b1);

    off     = longint'(addr) - longint'(base[d]);
    valid   = (off >= 0) && (off < nregs[d] * 4) && (addr % 4 == 0);
    idx     = valid ? int'(off / 4) : 0;
    exp_err = !valid || (wr && idx == 0 && strb != 4'h0);
    commit  = wr && !exp_err && strb != 4'h0;
    exp_rd  = 32'h0;
    if (!wr && !exp_err) exp_rd = (idx == 0) ? ID : mdl[d][idx];
    exp_pulse = 12'h0;
    if (commit) begin
      for (int i = 0; i < 4; i++)
        if (strb[i]) mdl[d][idx][8*i +: 8] = data[8*i +: 8];
      exp_pulse[(d ? 8 : 0) + idx] = 1'b1;
    end

    chk("latency", lat, waitc[d] + 1);
    chk("pslverr", er, exp_err);
    chk("prdata", rd, exp_rd);
    last_rd = rd; last_err = er;

    @(posedge PCLK); #1;
    chk("wr_pulse", {pulse_b, pulse_a}, exp_pulse);
    chk_regs();
  endtask

  task automatic idle();
    psel = 2'b00; penable = 1'b0;
    @(posedge PCLK); #1;
    chk("pulse_idle", {pulse_b, pulse_a}, 12'h0);
  endtask

  initial begin
    PRESETn = 1'b0;
    psel = 2'b00; penable = 1'b0; pwrite = 1'b0;
    paddr = 32'h0; pwdata = 32'h0; pstrb = 4'h0;
    m_reset();
    repeat (3) @(posedge PCLK);
    #1;
    chk("reset_pready", {bus_b.PREADY, bus_a.PREADY}, 2'b00);
    chk("reset_pslverr", {bus_b.PSLVERR, bus_a.PSLVERR}, 2'b00);
    chk("reset_prdata", {bus_b.PRDATA, bus_a.PRDATA}, 64'h0);
    chk("reset_pulse", {pulse_b, pulse_a}, 12'h0);
    chk_regs();
    @(negedge PCLK); PRESETn = 1'b1;
    @(posedge PCLK); #1;

    // ID read with one wait state
    xfer(0, 0, 32'h0, 32'h0, 4'h0);
    chk("id_read", last_rd, 32'hA9B0_0001);
    idle();

    // full write, partial write, read back
    xfer(0, 1, 32'h4, 32'hDEAD_BEEF, 4'b1111); idle();
    xfer(0, 1, 32'h4, 32'h0000_1122, 4'b0011); idle();
    xfer(0, 0, 32'h4, 32'h0, 4'h0);
    chk("merge_read", last_rd, 32'hDEAD_1122);
    chk("merge_regs", regs_a[63:32], 32'hDEAD_1122);
    idle();

    // bad accesses
    xfer(0, 1, 32'h20, 32'h1234_5678, 4'hF); chk("err_range", last_err, 1'b1); idle();
    xfer(0, 1, 32'h6, 32'h1234_5678, 4'hF);  chk("err_align", last_err, 1'b1); idle();
    xfer(0, 1, 32'h0, 32'h1234_5678, 4'hF);  chk("err_id_wr", last_err, 1'b1); idle();
    xfer(0, 1, 32'h0, 32'h1234_5678, 4'h0);  chk("id_zero_strb", last_err, 1'b0); idle();

    // back-to-back write then read
    xfer(0, 1, 32'h8, 32'h0000_0011, 4'hF);
    xfer(0, 0, 32'h8, 32'h0, 4'h0);
    chk("b2b_read", last_rd, 32'h0000_0011);
    idle();

    // zero-wait instance with non-zero base
    xfer(1, 1, 32'h0000_100C, 32'h5A5A_5A5A, 4'hF); idle();
    xfer(1, 0, 32'h0000_100C, 32'h0, 4'h0);
    chk("nowait_read", last_rd, 32'h5A5A_5A5A);
    idle();
    xfer(1, 0, 32'h0000_0FFC, 32'h0, 4'h0); chk("err_below_base", last_err, 1'b1); idle();
    xfer(1, 0, 32'h0000_1010, 32'h0, 4'h0); chk("err_above_top", last_err, 1'b1); idle();

    // PSEL dropped mid-wait: no write, no pulse, bus recovers
    psel = 2'b01; penable = 1'b0; pwrite = 1'b1;
    paddr = 32'h4; pwdata = 32'hCAFE_F00D; pstrb = 4'hF;
    @(posedge PCLK); #1; penable = 1'b1;
    @(posedge PCLK); #1; psel = 2'b00; penable = 1'b0;
    @(posedge PCLK); #1;
    chk("abort_pulse", {pulse_b, pulse_a}, 12'h0);
    chk_regs();
    xfer(0, 0, 32'h4, 32'h0, 4'h0); idle();

    // randomized traffic
    for (int n = 0; n < 80; n++) begin
      int          d = int'($urandom_range(0, 1));
      int          sel = int'($urandom_range(0, 9));
      logic [31:0] a;
      case (sel)
        6:       a = base[d] + 32'(4 * $urandom_range(0, nregs[d] - 1)) + 32'($urandom_range(1, 3));
        7:       a = base[d] + 32'(4 * nregs[d]) + 32'(4 * $urandom_range(0, 3));
        8:       a = d ? 32'h0000_0FF0 + 32'(4 * $urandom_range(0, 3)) : 32'h8000_0000;
        9:       a = base[d];
        default: a = base[d] + 32'(4 * $urandom_range(1, nregs[d] - 1));
      endcase
      xfer(d, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 1) == 0) idle();
    end
    idle();

    // reset in the middle of a write's wait state
    xfer(0, 1, 32'h4, 32'h0BAD_0BAD, 4'hF); idle();
    psel = 2'b01; penable = 1'b0; pwrite = 1'b1;
    paddr = 32'h4; pwdata = 32'hFFFF_FFFF; pstrb = 4'hF;
    @(posedge PCLK); #1; penable = 1'b1;
    @(negedge PCLK);
    PRESETn = 1'b0;
    m_reset();
    #1;
    chk("reset_mid_pready", bus_a.PREADY, 1'b0);
    chk_regs();
    @(posedge PCLK); #1;
    chk("reset_mid_pready_edge", bus_a.PREADY, 1'b0);
    psel = 2'b00; penable = 1'b0;
    @(negedge PCLK); PRESETn = 1'b1;
    @(posedge PCLK); #1;
    chk("reset_mid_pulse", {pulse_b, pulse_a}, 12'h0);
    xfer(0, 0, 32'h4, 32'h0, 4'h0);
    chk("reset_mid_read", last_rd, 32'h0);
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
